bus_protocol_checker: RTL and testbench

Synthesizable-style protocol monitor that sits directly downstream of the bus interface unit. It samples dValid/dAck/data on every rising clock and tracks each transfer with a state machine. It reports timing and data-integrity violations as one-cycle pulses, sticky flags and counters for benches and waveform debug. It is passive: it drives nothing back onto the bus.

---
 rtl/bus_protocol_checker_if.sv | 13 +
 rtl/bus_protocol_checker.sv | 200 ++++++++++++++++++++
 tb/tb_bus_protocol_checker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_protocol_checker_if.sv
// Bus bundle watched by the protocol checker: valid/data come from the interface unit,
// ack comes from the target. The checker only ever uses the monitor view.
interface bus_protocol_checker_if #(
   parameter int DATA_W = 8
);
   logic              dValid;
   logic              dAck;
   logic [DATA_W-1:0] data;

   modport master  (output dValid, output data, input dAck);
   modport slave   (input dValid, input data, output dAck);
   modport monitor (input dValid, input dAck, input data);
endinterface

// File: rtl/bus_protocol_checker.sv
// Passive protocol monitor: follows each valid/ack transfer and reports timing and
// data-integrity violations as registered pulses, sticky flags and saturating counters.
module bus_protocol_checker #(
   parameter int DATA_W  = 8,
   parameter int MIN_ACK = 2,
   parameter int MAX_ACK = 4,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   bus_protocol_checker_if.monitor bus,
   input  logic                   clr,
   output logic [6:0]             err_pulse,
   output logic [6:0]             err_sticky,
   output logic                   txn_done,
   output logic [CNT_W-1:0]       txn_count,
   output logic [CNT_W-1:0]       err_count,
   output logic [DATA_W-1:0]      last_data
);

   localparam int CW = $clog2(MAX_ACK + 2);
   localparam logic [CW-1:0] MinAck = CW'(MIN_ACK);
   localparam logic [CW-1:0] MaxAck = CW'(MAX_ACK);

   localparam int EarlyAck     = 0;
   localparam int LateAck      = 1;
   localparam int ValidDrop    = 2;
   localparam int ValidHold    = 3;
   localparam int DataUnstable = 4;
   localparam int DataUnknown  = 5;
   localparam int SpuriousAck  = 6;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACKED,
      ABORT
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cntNext;
   logic [CW-1:0]     cntPlus;
   logic [DATA_W-1:0] refData;
   logic [DATA_W-1:0] refNext;
   logic              unstableSeen;
   logic              unstableSeenNext;
   logic              unknownSeen;
   logic              unknownSeenNext;
   logic [6:0]        errNext;
   logic              acceptClean;
   logic              dataParity;
   logic              dataIsUnknown;
   logic              dataIsUnstable;

   // The parity of an X/Z-contaminated word is itself neither 0 nor 1, so this only
   // ever flags in a four-state simulator and reduces to constant 0 in hardware.
   always_comb begin
      dataParity     = ^bus.data;
      dataIsUnknown  = (dataParity !== 1'b0) && (dataParity !== 1'b1);
      dataIsUnstable = !dataIsUnknown && (bus.data !== refData);
   end

   // Next-state and per-sample rule evaluation; every violation is collected in errNext
   // and registered below so all reporting lags the offending sample by one clock.
   always_comb begin
      stateNext        = state;
      cntNext          = cnt;
      cntPlus          = cnt + 1'b1;
      refNext          = refData;
      unstableSeenNext = unstableSeen;
      unknownSeenNext  = unknownSeen;
      errNext          = '0;
      acceptClean      = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.dValid) begin
               refNext          = bus.data;
               cntNext          = '0;
               unstableSeenNext = 1'b0;
               unknownSeenNext  = 1'b0;
               if (bus.dAck) begin
                  errNext[EarlyAck] = 1'b1;
                  stateNext         = ABORT;
               end else begin
                  stateNext = WAIT;
               end
            end else if (bus.dAck) begin
               errNext[SpuriousAck] = 1'b1;
            end
         end

         WAIT: begin
            cntNext = cntPlus;
            // Data rules are one-shot per transfer and skip the sample where valid drops away.
            if (bus.dValid || bus.dAck) begin
               if (dataIsUnstable && !unstableSeen) begin
                  errNext[DataUnstable] = 1'b1;
                  unstableSeenNext      = 1'b1;
               end
               if (dataIsUnknown && !unknownSeen) begin
                  errNext[DataUnknown] = 1'b1;
                  unknownSeenNext      = 1'b1;
               end
            end
            if (bus.dAck) begin
               if (cntPlus < MinAck) begin
                  errNext[EarlyAck] = 1'b1;
                  stateNext         = ABORT;
               end else if (cntPlus <= MaxAck) begin
                  stateNext   = ACKED;
                  acceptClean = !(unstableSeenNext || unknownSeenNext);
               end else begin
                  errNext[LateAck] = 1'b1;
                  stateNext        = ABORT;
               end
            end else if (!bus.dValid) begin
               errNext[ValidDrop] = 1'b1;
               stateNext          = IDLE;
            end else if (cntPlus > MaxAck) begin
               errNext[LateAck] = 1'b1;
               stateNext        = ABORT;
            end
         end

         ACKED: begin
            if (bus.dValid) begin
               errNext[ValidHold] = 1'b1;
               stateNext          = ABORT;
            end else begin
               if (bus.dAck) begin
                  errNext[SpuriousAck] = 1'b1;
               end
               stateNext = IDLE;
            end
         end

         ABORT: begin
            if (!bus.dValid) begin
               stateNext = IDLE;
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Transfer-tracking state: FSM, sample counter, reference data and one-shot flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         refData      <= '0;
         unstableSeen <= 1'b0;
         unknownSeen  <= 1'b0;
      end else begin
         state        <= stateNext;
         cnt          <= cntNext;
         refData      <= refNext;
         unstableSeen <= unstableSeenNext;
         unknownSeen  <= unknownSeenNext;
      end
   end

   // Reporting registers; clr only touches the accumulated values, never the pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_pulse  <= '0;
         err_sticky <= '0;
         txn_done   <= 1'b0;
         txn_count  <= '0;
         err_count  <= '0;
         last_data  <= '0;
      end else begin
         err_pulse <= errNext;
         txn_done  <= acceptClean;
         if (acceptClean) begin
            last_data <= bus.data;
         end
         if (clr) begin
            err_sticky <= '0;
            txn_count  <= '0;
            err_count  <= '0;
         end else begin
            err_sticky <= err_sticky | errNext;
            if (acceptClean && (txn_count != {CNT_W{1'b1}})) begin
               txn_count <= txn_count + 1'b1;
            end
            if ((|errNext) && (err_count != {CNT_W{1'b1}})) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_protocol_checker.sv
// Directed bench for bus_protocol_checker: one task per scenario, expected values worked
// out by hand for MIN_ACK=2, MAX_ACK=4 and carried forward in a few running totals.
module tb_bus_protocol_checker;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              clr;
   logic [6:0]        err_pulse;
   logic [6:0]        err_sticky;
   logic              txn_done;
   logic [CNT_W-1:0]  txn_count;
   logic [CNT_W-1:0]  err_count;
   logic [DATA_W-1:0] last_data;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [CNT_W-1:0]  expTxn;
   logic [CNT_W-1:0]  expErrCnt;
   logic [6:0]        expSticky;
   logic [DATA_W-1:0] expLast;
   logic              xSupported;

   bus_protocol_checker_if #(.DATA_W(DATA_W)) bus ();

   bus_protocol_checker #(
      .DATA_W (DATA_W),
      .MIN_ACK(2),
      .MAX_ACK(4),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .clr       (clr),
      .err_pulse (err_pulse),
      .err_sticky(err_sticky),
      .txn_done  (txn_done),
      .txn_count (txn_count),
      .err_count (err_count),
      .last_data (last_data)
   );

   always #5 clk = ~clk;

   // Drives one bus sample from a negedge and returns at the following negedge,
   // so the registered response to that sample is visible on return.
   task automatic applyStimulus(input logic v, input logic a, input logic [DATA_W-1:0] d);
      bus.dValid = v;
      bus.dAck   = a;
      bus.data   = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clr   = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL reset_err_pulse: got %h, expected 00", err_pulse); end
      testsRun++; if (err_sticky !== 7'h00) begin testsFailed++; $display("[TB] FAIL reset_err_sticky: got %h, expected 00", err_sticky); end
      testsRun++; if (txn_count !== 16'd0 || err_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_counts: got %0d/%0d, expected 0/0", txn_count, err_count); end
      testsRun++; if (txn_done !== 1'b0 || last_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_done_last: got %b/%h, expected 0/00", txn_done, last_data); end
      reset = 1'b0;
      expTxn = '0; expErrCnt = '0; expSticky = '0; expLast = '0;
   endtask

   task automatic test_clean_transfer();
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h00);
      expTxn = expTxn + 1'b1;
      testsRun++; if (txn_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL clean_ack2_done: got %b, expected 1", txn_done); end
      testsRun++; if (txn_count !== expTxn) begin testsFailed++; $display("[TB] FAIL clean_ack2_count: got %0d, expected %0d", txn_count, expTxn); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (txn_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL clean_done_oneshot: got %b, expected 0", txn_done); end
      testsRun++; if (err_sticky !== 7'h00) begin testsFailed++; $display("[TB] FAIL clean_sticky: got %h, expected 00", err_sticky); end
      // Ack on the last legal sample, immediately back-to-back with the previous transfer.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'hA5);
      applyStimulus(1'b1, 1'b1, 8'hA5);
      expTxn = expTxn + 1'b1; expLast = 8'hA5;
      testsRun++; if (txn_done !== 1'b1 || txn_count !== expTxn) begin testsFailed++; $display("[TB] FAIL clean_ack4: got done=%b count=%0d, expected done=1 count=%0d", txn_done, txn_count, expTxn); end
      testsRun++; if (last_data !== expLast) begin testsFailed++; $display("[TB] FAIL clean_last_data: got %h, expected %h", last_data, expLast); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_count !== expErrCnt || err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL clean_no_errors: got cnt=%0d pulse=%h, expected cnt=%0d pulse=00", err_count, err_pulse, expErrCnt); end
   endtask

   task automatic test_late_ack();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h3C);
         testsRun++; if (err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL late_premature_pulse s%0d: got %h, expected 00", i, err_pulse); end
      end
      applyStimulus(1'b1, 1'b1, 8'h3C);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h02;
      testsRun++; if (err_pulse !== 7'h02) begin testsFailed++; $display("[TB] FAIL late_pulse: got %h, expected 02", err_pulse); end
      testsRun++; if (err_count !== expErrCnt || txn_count !== expTxn || txn_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL late_counts: got err=%0d txn=%0d done=%b, expected err=%0d txn=%0d done=0", err_count, txn_count, txn_done, expErrCnt, expTxn); end
      // Still in ABORT: an ack now must be ignored rather than flagged.
      applyStimulus(1'b1, 1'b1, 8'h3C);
      testsRun++; if (err_pulse !== 7'h00 || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL late_abort_quiet: got pulse=%h err=%0d, expected 00/%0d", err_pulse, err_count, expErrCnt); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_sticky !== expSticky) begin testsFailed++; $display("[TB] FAIL late_sticky: got %h, expected %h", err_sticky, expSticky); end
   endtask

   task automatic test_valid_hold();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h55);
      applyStimulus(1'b1, 1'b1, 8'h55);
      expTxn = expTxn + 1'b1; expLast = 8'h55;
      applyStimulus(1'b1, 1'b0, 8'h55);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h08;
      testsRun++; if (err_pulse !== 7'h08) begin testsFailed++; $display("[TB] FAIL hold_pulse: got %h, expected 08", err_pulse); end
      testsRun++; if (txn_count !== expTxn || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL hold_counts: got txn=%0d err=%0d, expected txn=%0d err=%0d", txn_count, err_count, expTxn, expErrCnt); end
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_valid_drop();
      applyStimulus(1'b1, 1'b0, 8'h66);
      applyStimulus(1'b0, 1'b0, 8'h66);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h04;
      testsRun++; if (err_pulse !== 7'h04 || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL drop_pulse: got pulse=%h err=%0d, expected 04/%0d", err_pulse, err_count, expErrCnt); end
      applyStimulus(1'b0, 1'b1, 8'h00);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h40;
      testsRun++; if (err_pulse !== 7'h40 || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL spurious_idle: got pulse=%h err=%0d, expected 40/%0d", err_pulse, err_count, expErrCnt); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_sticky !== expSticky) begin testsFailed++; $display("[TB] FAIL drop_sticky: got %h, expected %h", err_sticky, expSticky); end
   endtask

   task automatic test_early_ack();
      applyStimulus(1'b1, 1'b0, 8'h77);
      applyStimulus(1'b1, 1'b1, 8'h77);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h01;
      testsRun++; if (err_pulse !== 7'h01 || txn_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL early_wait: got pulse=%h done=%b, expected 01/0", err_pulse, txn_done); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h77);
      expErrCnt = expErrCnt + 1'b1;
      testsRun++; if (err_pulse !== 7'h01 || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL early_idle: got pulse=%h err=%0d, expected 01/%0d", err_pulse, err_count, expErrCnt); end
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_data_unknown();
      logic [DATA_W-1:0] ackData;
      logic [6:0]        expPulse;
      logic              expDone;
      ackData = 8'h11;
      if (xSupported) ackData = 8'hxx;
      applyStimulus(1'b1, 1'b0, 8'h11);
      applyStimulus(1'b1, 1'b0, 8'h11);
      applyStimulus(1'b1, 1'b1, ackData);
      if (xSupported) begin
         expPulse = 7'h20; expDone = 1'b0;
         expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h20;
      end else begin
         expPulse = 7'h00; expDone = 1'b1;
         expTxn = expTxn + 1'b1; expLast = 8'h11;
      end
      testsRun++; if (err_pulse !== expPulse || txn_done !== expDone) begin testsFailed++; $display("[TB] FAIL unknown_pulse: got pulse=%h done=%b, expected %h/%b", err_pulse, txn_done, expPulse, expDone); end
      testsRun++; if (txn_count !== expTxn || last_data !== expLast) begin testsFailed++; $display("[TB] FAIL unknown_txn: got txn=%0d last=%h, expected %0d/%h", txn_count, last_data, expTxn, expLast); end
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_data_unstable();
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h01);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h10;
      testsRun++; if (err_pulse !== 7'h10) begin testsFailed++; $display("[TB] FAIL unstable_pulse: got %h, expected 10", err_pulse); end
      applyStimulus(1'b1, 1'b0, 8'h00);
      testsRun++; if (err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL unstable_restored: got %h, expected 00", err_pulse); end
      applyStimulus(1'b1, 1'b1, 8'h01);
      testsRun++; if (err_pulse !== 7'h00 || txn_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL unstable_once: got pulse=%h done=%b, expected 00/0", err_pulse, txn_done); end
      testsRun++; if (txn_count !== expTxn || last_data !== expLast || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL unstable_counts: got txn=%0d last=%h err=%0d, expected %0d/%h/%0d", txn_count, last_data, err_count, expTxn, expLast, expErrCnt); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_sticky !== expSticky) begin testsFailed++; $display("[TB] FAIL unstable_sticky: got %h, expected %h", err_sticky, expSticky); end
   endtask

   task automatic test_reset_mid_transfer();
      applyStimulus(1'b1, 1'b0, 8'h22);
      applyStimulus(1'b1, 1'b0, 8'h22);
      reset = 1'b1;
      #1;
      testsRun++; if (err_sticky !== 7'h00 || txn_count !== 16'd0 || err_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL async_reset_counts: got sticky=%h txn=%0d err=%0d, expected 00/0/0", err_sticky, txn_count, err_count); end
      testsRun++; if (last_data !== 8'h00 || err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL async_reset_outputs: got last=%h pulse=%h, expected 00/00", last_data, err_pulse); end
      @(negedge clk);
      reset = 1'b0;
      expTxn = '0; expErrCnt = '0; expSticky = '0;
      applyStimulus(1'b1, 1'b0, 8'h22);
      applyStimulus(1'b1, 1'b0, 8'h22);
      applyStimulus(1'b1, 1'b1, 8'h22);
      expTxn = expTxn + 1'b1; expLast = 8'h22;
      testsRun++; if (txn_done !== 1'b1 || err_pulse !== 7'h00) begin testsFailed++; $display("[TB] FAIL reset_fresh_txn: got done=%b pulse=%h, expected 1/00", txn_done, err_pulse); end
      testsRun++; if (txn_count !== expTxn || last_data !== expLast) begin testsFailed++; $display("[TB] FAIL reset_fresh_count: got txn=%0d last=%h, expected %0d/%h", txn_count, last_data, expTxn, expLast); end
      applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_clr();
      applyStimulus(1'b0, 1'b1, 8'h00);
      expErrCnt = expErrCnt + 1'b1; expSticky = expSticky | 7'h40;
      testsRun++; if (err_sticky !== expSticky || err_count !== expErrCnt) begin testsFailed++; $display("[TB] FAIL clr_setup: got sticky=%h err=%0d, expected %h/%0d", err_sticky, err_count, expSticky, expErrCnt); end
      // clr lands on the same sample as a fresh violation: the pulse survives, the totals do not.
      clr = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'h00);
      clr = 1'b0;
      expErrCnt = '0; expSticky = '0; expTxn = '0;
      testsRun++; if (err_pulse !== 7'h40) begin testsFailed++; $display("[TB] FAIL clr_pulse_kept: got %h, expected 40", err_pulse); end
      testsRun++; if (err_sticky !== expSticky || err_count !== expErrCnt || txn_count !== expTxn) begin testsFailed++; $display("[TB] FAIL clr_cleared: got sticky=%h err=%0d txn=%0d, expected 00/0/0", err_sticky, err_count, txn_count); end
      testsRun++; if (last_data !== expLast) begin testsFailed++; $display("[TB] FAIL clr_last_data: got %h, expected %h", last_data, expLast); end
      applyStimulus(1'b0, 1'b0, 8'h00);
      testsRun++; if (err_pulse !== 7'h00 || err_sticky !== 7'h00 || err_count !== 16'd0) begin testsFailed++; $display("[TB] FAIL clr_after: got pulse=%h sticky=%h err=%0d, expected 00/00/0", err_pulse, err_sticky, err_count); end
   endtask

   initial begin
      logic probe;
      probe      = 1'bx;
      xSupported = (probe !== 1'b0) && (probe !== 1'b1);
      reset      = 1'b1;
      clr        = 1'b0;
      bus.dValid = 1'b0;
      bus.dAck   = 1'b0;
      bus.data   = '0;
      @(negedge clk);
      test_reset();
      test_clean_transfer();
      test_late_ack();
      test_valid_hold();
      test_valid_drop();
      test_early_ack();
      test_data_unknown();
      test_data_unstable();
      test_reset_mid_transfer();
      test_clr();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
